regfile_wr_ctrl: RTL and testbench
==================================

# regfile_wr_ctrl

Write-port controller for the 32×32 integer register file. It owns the register file's single write port (write enable, write address, write data) and initialises all of registers x1..x31 after reset, because the register file itself has no reset. After initialisation it arbitrates that one port between two writeback requesters: requester 0 is the ALU/execute writeback and requester 1 is the load/memory writeback. It sits between the writeback stage and the register file.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; must be a power of two
- INIT_VAL, 32'h0, value written to x1..x(NREG-1) during initialisation

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_req  in  1  one-cycle pulse that requests re-initialisation; sampled only in RUN
- init_done  out  1  high while the controller is in RUN
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 write accepted this cycle
- req0_addr  in  log2(NREG)  requester 0 destination register
- req0_data  in  XLEN  requester 0 write data
- req1_valid / req1_ready / req1_addr / req1_data  same as requester 0, for requester 1
- rf_we  out  1  register-file write enable (drives WE3)
- rf_a3  out  log2(NREG)  register-file write address (drives A3)
- rf_wd3  out  XLEN  register-file write data (drives WD3)

## Operation
- Two states: INIT and RUN. Reset enters INIT with sweep counter = 1.
- INIT, each cycle:
  - rf_we=1, rf_a3=counter, rf_wd3=INIT_VAL; counter increments.
  - After address NREG-1 is issued, next state is RUN.
  - req0_ready and req1_ready are 0.
- RUN: round-robin arbitration between the two requesters.
  - A priority bit `pri` resets to 0, meaning requester 0 wins a conflict.
  - Only one requester valid: it is granted.
  - Both valid: requester `pri` is granted.
  - After any grant to requester i, `pri` becomes 1-i. `pri` is unchanged in cycles with no grant.
  - reqN_ready is combinational: state==RUN, no init_req, and grant to N. At most one ready is high per cycle.
  - Ready does not depend on the requester's own address or data.
- Accepted write (valid & ready at a rising edge): on that edge the registered outputs load rf_we=1, rf_a3=addr, rf_wd3=data.
- Writes to address 0 are accepted (ready=1) but load rf_we=0, so x0 stays hardwired to zero.
- A cycle with no accept loads rf_we=0. rf_a3 and rf_wd3 hold their previous values.
- init_req=1 in RUN: both readies are 0 that cycle, and the next state is INIT with counter=1, so a full re-sweep follows. init_req in INIT is ignored.
- Reset asserted mid-sweep or mid-RUN: all state returns to reset values immediately, and the sweep restarts after rst_n deasserts.

## Timing
- Reset values: rf_we=0, rf_a3=0, rf_wd3=0, init_done=0, req0_ready=0, req1_ready=0, pri=0, state=INIT.
- Sweep sequence, counting rising edges after rst_n deasserts:
  - Edge 1: rf_we=1, rf_a3=1.
  - Edge k: rf_a3=k, up to edge NREG-1.
  - Edge NREG: init_done=1, rf_we=0.
- Initialisation takes NREG-1 write cycles (31 by default). Readies can first be high in the cycle after edge NREG.
- Write latency:
  - A write accepted at edge k drives rf_we during cycle k..k+1.
  - The register file captures it at edge k+1.
  - Reads show the new value from edge k+1 onward.
  - Downstream forwarding compares against rf_we/rf_a3/rf_wd3 during that window.
- Throughput: one write per cycle. Under continuous two-requester contention, the grants alternate 0,1,0,1…
- init_done drops on the edge that samples init_req=1, so it is low in the following cycle.

## Structure
- The shared package rv_pkg holds:
  - XLEN
  - NREG
  - REG_AW = log2(NREG)
  - the state enum {ST_INIT, ST_RUN}
- Sub-module rr_arb2: a 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], en.
  - Outputs: gnt[1:0], one-hot or zero.
  - It owns the `pri` flop.
- The top level holds the FSM, the sweep counter and the output registers.

## Test plan
- Reset release, no requests → rf_we=1 for 31 consecutive cycles with rf_a3=1..31 and rf_wd3=0. init_done=1 at edge 32. A register-file model then reads 0 from every register.
- RUN, only req0 valid with addr=5 and data=32'hDEADBEEF → req0_ready=1 in the same cycle. Next cycle rf_we=1, rf_a3=5. The register file reads back DEADBEEF one edge later.
- Both requesters valid for 4 cycles (req0 addr=1, req1 addr=2) → grant order 0,1,0,1, and rf_a3 follows 1,2,1,2.
- req1 valid with addr=0 and data=32'hFFFFFFFF → req1_ready=1, rf_we stays 0, and RD of x0 stays 0.
- Pulse init_req while req0 is valid → req0_ready=0 that cycle, init_done=0 next cycle, then a full 31-cycle sweep. req0 is granted after init_done=1.
- Assert rst_n=0 at sweep address 10 → outputs reset immediately. After release the sweep restarts at rf_a3=1.

Source files
------------

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the integer register-file write path.
//   XLEN   : integer data width
//   NREG   : number of architectural registers (power of two)
//   REG_AW : register address width, log2(NREG)
//   state_e: write-port controller state (initialisation sweep / normal run)
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the requests
// and the stored priority bit; the priority bit moves away from whichever
// requester was granted, so sustained contention alternates 0,1,0,1...
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request lines
//   en         : when low no grant is issued and the priority is left alone
//   gnt[1:0]   : grant, one-hot or zero
// -----------------------------------------------------------------------------
module rr_arb2
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // pri_q names the requester that wins the next conflict
  logic pri_q;
  logic pri_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = pri_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Hand priority to the other requester after any grant
  always_comb begin
    pri_d = pri_q;
    if (gnt[0]) begin
      pri_d = 1'b1;
    end else if (gnt[1]) begin
      pri_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wr_ctrl
// Owns the single write port of the integer register file. After reset (or an
// init_req pulse) it sweeps x1..x(NREG-1) with INIT_VAL, since the register
// file itself has no reset, then arbitrates the port between the execute
// writeback (requester 0) and the load writeback (requester 1).
//   clk, rst_n        : clock, asynchronous active-low reset
//   init_req          : request a full re-initialisation (honoured in RUN only)
//   init_done         : high while in RUN
//   reqN_valid/ready  : requester handshake, ready is combinational
//   reqN_addr/data    : requester destination register and write data
//   rf_we/rf_a3/rf_wd3: registered register-file write port (WE3/A3/WD3)
// -----------------------------------------------------------------------------
module regfile_wr_ctrl
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter int              NREG     = rv_pkg::NREG,
  parameter logic [XLEN-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    init_done,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [$clog2(NREG)-1:0] req0_addr,
  input  logic [XLEN-1:0]         req0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [$clog2(NREG)-1:0] req1_addr,
  input  logic [XLEN-1:0]         req1_data,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_a3,
  output logic [XLEN-1:0]         rf_wd3
);

  localparam int AW = $clog2(NREG);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_a3_q, rf_a3_d;
  logic [XLEN-1:0] rf_wd3_q, rf_wd3_d;

  logic            arb_en;
  logic [1:0]      gnt;

  // A pending re-initialisation blocks every grant in the same cycle
  assign arb_en = (state_q == ST_RUN) && !init_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign init_done  = (state_q == ST_RUN);

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

  // The sweep counter starts at 1 and wraps to 0 once x(NREG-1) has been
  // issued; the wrapped value marks the one idle cycle before RUN, which
  // makes init_done rise on the edge after the last sweep write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rf_we_d  = 1'b1;
          rf_a3_d  = cnt_q;
          rf_wd3_d = INIT_VAL;
          cnt_d    = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = AW'(1);
        end else if (gnt[0]) begin
          // x0 is hardwired: accept the write but never enable it
          rf_we_d  = (req0_addr != '0);
          rf_a3_d  = req0_addr;
          rf_wd3_d = req0_data;
        end else if (gnt[1]) begin
          rf_we_d  = (req1_addr != '0);
          rf_a3_d  = req1_addr;
          rf_wd3_d = req1_data;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= AW'(1);
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_ctrl
// Bench for regfile_wr_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model of the write-port controller and a golden register-file image.
// -----------------------------------------------------------------------------
module tb_regfile_wr_ctrl;
  import rv_pkg::*;

  localparam logic [XLEN-1:0] INIT_VAL = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_req = 1'b0;
  logic              init_done;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [REG_AW-1:0] req0_addr = '0;
  logic [XLEN-1:0]   req0_data = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [REG_AW-1:0] req1_addr = '0;
  logic [XLEN-1:0]   req1_data = '0;
  logic              rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd3;

  int checks   = 0;
  int failures = 0;

  regfile_wr_ctrl #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_req),
    .init_done  (init_done),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT's write port; no reset, x0 starts at zero
  // and everything else at garbage so a missing sweep write shows up.
  logic [XLEN-1:0] rf_mem [NREG] = '{0: 32'h0, default: 32'hA5A5_5A5A};

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_a3] <= rf_wd3;
  end

  // Behavioural model: m_run says whether the controller is past its sweep,
  // m_sweep counts sweep edges, m_pri is who wins the next conflict,
  // e_* are the write-port values the DUT must present, gold[] is what the
  // register file must hold once the last write has landed.
  bit                m_run   = 1'b0;
  int                m_sweep = 0;
  int                m_pri   = 0;
  logic              e_we    = 1'b0;
  logic [REG_AW-1:0] e_a3    = '0;
  logic [XLEN-1:0]   e_wd3   = '0;
  logic [XLEN-1:0]   gold [NREG] = '{default: 32'h0};

  function automatic int modelGrant();
    if (!m_run || init_req) return -1;
    if (req0_valid && req1_valid) return m_pri;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_sweep <= 0;
      m_pri   <= 0;
      e_we    <= 1'b0;
      e_a3    <= '0;
      e_wd3   <= '0;
    end else if (!m_run) begin
      if (m_sweep < NREG - 1) begin
        e_we               <= 1'b1;
        e_a3               <= REG_AW'(m_sweep + 1);
        e_wd3              <= INIT_VAL;
        gold[m_sweep + 1]  <= INIT_VAL;
        m_sweep            <= m_sweep + 1;
      end else begin
        e_we  <= 1'b0;
        m_run <= 1'b1;
      end
    end else if (init_req) begin
      m_run   <= 1'b0;
      m_sweep <= 0;
      e_we    <= 1'b0;
    end else begin
      case (modelGrant())
        0: begin
          e_we  <= (req0_addr != 0);
          e_a3  <= req0_addr;
          e_wd3 <= req0_data;
          if (req0_addr != 0) gold[req0_addr] <= req0_data;
          m_pri <= 1;
        end
        1: begin
          e_we  <= (req1_addr != 0);
          e_a3  <= req1_addr;
          e_wd3 <= req1_data;
          if (req1_addr != 0) gold[req1_addr] <= req1_data;
          m_pri <= 0;
        end
        default: e_we <= 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Every cycle, midway between edges, the DUT must match the model
  always @(negedge clk) begin
    int g;
    g = modelGrant();
    checkOutput("cyc_init_done", init_done, m_run);
    checkOutput("cyc_req0_ready", req0_ready, (g == 0));
    checkOutput("cyc_req1_ready", req1_ready, (g == 1));
    checkOutput("cyc_rf_we", rf_we, e_we);
    checkOutput("cyc_rf_a3", rf_a3, e_a3);
    checkOutput("cyc_rf_wd3", rf_wd3, e_wd3);
  end

  task automatic applyStimulus(input logic v0, input logic [REG_AW-1:0] a0, input logic [XLEN-1:0] d0,
                               input logic v1, input logic [REG_AW-1:0] a1, input logic [XLEN-1:0] d1,
                               input logic ireq);
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
    init_req   = ireq;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic checkRf();
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("rf_x%0d", i), rf_mem[i], gold[i]);
    end
  endtask

  task automatic waitInitDone(input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      stepClk();
      n++;
    end
    checkOutput("init_done_wait", init_done, 1);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rf_we", rf_we, 0);
    checkOutput("reset_init_done", init_done, 0);
    rst_n = 1'b1;

    // Initial sweep: edge 1 writes x1, edge 31 writes x31, edge 32 enters RUN
    stepClk();
    checkOutput("sweep_first_we", rf_we, 1);
    checkOutput("sweep_first_a3", rf_a3, 1);
    repeat (30) stepClk();
    checkOutput("sweep_last_a3", rf_a3, 31);
    checkOutput("sweep_last_init_done", init_done, 0);
    stepClk();
    checkOutput("run_init_done", init_done, 1);
    checkOutput("run_rf_we", rf_we, 0);
    stepClk();
    checkRf();

    // Single requester 0 write
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("r0_ready", req0_ready, 1);
    stepClk();
    idle();
    checkOutput("r0_we", rf_we, 1);
    checkOutput("r0_a3", rf_a3, 5);
    checkOutput("r0_wd3", rf_wd3, 32'hDEADBEEF);
    stepClk();
    checkOutput("r0_rf_x5", rf_mem[5], 32'hDEADBEEF);

    // Requester 1 writing x0: accepted, never enabled
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    #1;
    checkOutput("x0_ready", req1_ready, 1);
    stepClk();
    idle();
    checkOutput("x0_we", rf_we, 0);
    stepClk();
    checkOutput("x0_rf_x0", rf_mem[0], 0);

    // Continuous contention: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 32'(100 + i), 1'b1, 5'd2, 32'(200 + i), 1'b0);
      #1;
      checkOutput($sformatf("rr_ready0_%0d", i), req0_ready, (i % 2 == 0));
      checkOutput($sformatf("rr_ready1_%0d", i), req1_ready, (i % 2 == 1));
      stepClk();
      checkOutput($sformatf("rr_a3_%0d", i), rf_a3, (i % 2 == 0) ? 1 : 2);
    end
    idle();
    stepClk();

    // Re-initialisation while requester 0 waits
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, '0, '0, 1'b1);
    #1;
    checkOutput("reinit_ready0", req0_ready, 0);
    stepClk();
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, '0, '0, 1'b0);
    checkOutput("reinit_init_done", init_done, 0);
    repeat (31) stepClk();
    checkOutput("reinit_last_a3", rf_a3, 31);
    stepClk();
    checkOutput("reinit_done", init_done, 1);
    #1;
    checkOutput("reinit_ready0_after", req0_ready, 1);
    stepClk();
    idle();
    checkOutput("reinit_a3_after", rf_a3, 7);
    stepClk();

    // Randomized traffic, occasional re-initialisation requests
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), REG_AW'($urandom_range(0, NREG - 1)), $urandom,
                    1'($urandom_range(0, 1)), REG_AW'($urandom_range(0, NREG - 1)), $urandom,
                    ($urandom_range(0, 99) == 0));
      stepClk();
    end
    idle();
    waitInitDone(80);
    stepClk();
    checkRf();

    // Reset asserted mid-sweep at address 10
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    stepClk();
    idle();
    begin
      int n = 0;
      while (!(rf_we && rf_a3 == 5'd10) && n < 50) begin
        stepClk();
        n++;
      end
      checkOutput("midreset_reach_a3_10", rf_a3, 10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_we", rf_we, 0);
    checkOutput("midreset_a3", rf_a3, 0);
    checkOutput("midreset_init_done", init_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepClk();
    checkOutput("midreset_restart_a3", rf_a3, 1);
    checkOutput("midreset_restart_we", rf_we, 1);
    waitInitDone(40);
    stepClk();
    checkRf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
